// File: rtl/dmem_seq.sv
// Sequencer for the filter data memory: stores each accepted sample at the head of a
// circular delay line, then reads taps newest-to-oldest and flags returned data for the MAC.
package dmem_pkg;
  typedef enum logic [1:0] {
    DMEM_NOP   = 2'd0,
    DMEM_WREXT = 2'd1,
    DMEM_RD    = 2'd2
  } dmem_cmd_t;
endpackage

module dmem_seq
  import dmem_pkg::*;
#(
  parameter int DMEMSIZE = 16,
  parameter int AW       = $clog2(DMEMSIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid_in,
  input  logic [AW:0]   ntaps_in,
  output logic          ready_out,
  output dmem_cmd_t     cmd_out,
  output logic [AW-1:0] addr_out,
  output logic          tap_valid_out,
  output logic [AW-1:0] tap_idx_out,
  output logic          last_out,
  output logic          done_out,
  output logic          busy_out,
  output logic          overrun_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AW:0]   SIZE_L = (AW+1)'(DMEMSIZE);
  localparam logic [AW-1:0] HEAD_MAX = AW'(DMEMSIZE - 1);

  state_t        state;
  logic [AW-1:0] head;
  logic [AW-1:0] k;
  logic [AW:0]   n;

  function automatic logic [AW:0] clamp_taps(input logic [AW:0] t);
    if (t == '0)
      return (AW+1)'(1);
    else if (t > SIZE_L)
      return SIZE_L;
    else
      return t;
  endfunction

  // Explicit modular subtract so non-power-of-two depths wrap correctly.
  function automatic logic [AW-1:0] wrap_sub(input logic [AW-1:0] h, input logic [AW-1:0] d);
    logic [AW:0] r;
    if (h >= d)
      r = {1'b0, h} - {1'b0, d};
    else
      r = {1'b0, h} + SIZE_L - {1'b0, d};
    return r[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] h);
    if (h == HEAD_MAX)
      return '0;
    else
      return h + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      head          <= '0;
      k             <= '0;
      n             <= (AW+1)'(1);
      ready_out     <= 1'b1;
      busy_out      <= 1'b0;
      cmd_out       <= DMEM_NOP;
      addr_out      <= '0;
      tap_valid_out <= 1'b0;
      tap_idx_out   <= '0;
      last_out      <= 1'b0;
      done_out      <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      if (sample_valid_in && !ready_out)
        overrun_out <= 1'b1;

      case (state)
        S_IDLE: begin
          tap_valid_out <= 1'b0;
          last_out      <= 1'b0;
          done_out      <= 1'b0;
          cmd_out       <= DMEM_NOP;
          if (sample_valid_in) begin
            n         <= clamp_taps(ntaps_in);
            state     <= S_WRITE;
            cmd_out   <= DMEM_WREXT;
            addr_out  <= head;
            ready_out <= 1'b0;
            busy_out  <= 1'b1;
          end
        end
        S_WRITE: begin
          state    <= S_READ;
          cmd_out  <= DMEM_RD;
          addr_out <= head;
          k        <= '0;
        end
        S_READ: begin
          // Flags describe the RD currently on cmd_out; its data returns next cycle.
          tap_valid_out <= 1'b1;
          tap_idx_out   <= k;
          last_out      <= ({1'b0, k} == n - 1'b1);
          if ({1'b0, k} == n - 1'b1) begin
            state   <= S_DRAIN;
            cmd_out <= DMEM_NOP;
          end else begin
            k        <= k + 1'b1;
            addr_out <= wrap_sub(head, k + 1'b1);
          end
        end
        S_DRAIN: begin
          tap_valid_out <= 1'b0;
          last_out      <= 1'b0;
          done_out      <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE: begin
          done_out  <= 1'b0;
          ready_out <= 1'b1;
          busy_out  <= 1'b0;
          head      <= wrap_inc(head);
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_seq.sv
// Directed bench for dmem_seq: cycle-by-cycle checks of command, address, tap flags,
// handshake and overrun against hand-derived timing for DMEMSIZE=16.
module tb_dmem_seq;
  import dmem_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_valid_in;
  logic [4:0]    ntaps_in;
  logic          ready_out;
  dmem_cmd_t     cmd_out;
  logic [3:0]    addr_out;
  logic          tap_valid_out;
  logic [3:0]    tap_idx_out;
  logic          last_out;
  logic          done_out;
  logic          busy_out;
  logic          overrun_out;

  int errors = 0;
  int checks = 0;
  int exp_head = 0;
  bit exp_ovr = 1'b0;

  dmem_seq #(.DMEMSIZE(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_valid_in (sample_valid_in),
    .ntaps_in        (ntaps_in),
    .ready_out       (ready_out),
    .cmd_out         (cmd_out),
    .addr_out        (addr_out),
    .tap_valid_out   (tap_valid_out),
    .tap_idx_out     (tap_idx_out),
    .last_out        (last_out),
    .done_out        (done_out),
    .busy_out        (busy_out),
    .overrun_out     (overrun_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, " cmd"}, 32'(cmd_out), 32'(DMEM_NOP));
    chk({tag, " addr"}, 32'(addr_out), 0);
    chk({tag, " tap_valid"}, 32'(tap_valid_out), 0);
    chk({tag, " tap_idx"}, 32'(tap_idx_out), 0);
    chk({tag, " last"}, 32'(last_out), 0);
    chk({tag, " done"}, 32'(done_out), 0);
    chk({tag, " busy"}, 32'(busy_out), 0);
    chk({tag, " overrun"}, 32'(overrun_out), 0);
    chk({tag, " ready"}, 32'(ready_out), 1);
  endtask

  // Accept a sample at cycle 0 and check cycles 1..n+4. pulse_c: cycle in which a
  // stray valid is driven (-1 = none); chg: drop ntaps_in to 1 during READ.
  task automatic run_seq(input string name, input int ntaps, input int n,
                         input int pulse_c, input bit chg);
    int h;
    bit tv;
    h = exp_head;
    sample_valid_in = 1'b1;
    ntaps_in = 5'(ntaps);
    tick();
    sample_valid_in = 1'b0;
    for (int c = 1; c <= n + 4; c++) begin
      string t;
      t = $sformatf("%s h%0d c%0d", name, h, c);
      if (c == 1) begin
        chk({t, " cmd"}, 32'(cmd_out), 32'(DMEM_WREXT));
        chk({t, " addr"}, 32'(addr_out), 32'(h));
      end else if (c <= n + 1) begin
        chk({t, " cmd"}, 32'(cmd_out), 32'(DMEM_RD));
        chk({t, " addr"}, 32'(addr_out), 32'((h - (c - 2) + 16) % 16));
      end else begin
        chk({t, " cmd"}, 32'(cmd_out), 32'(DMEM_NOP));
      end
      tv = (c >= 3) && (c <= n + 2);
      chk({t, " tap_valid"}, 32'(tap_valid_out), 32'(tv));
      if (tv)
        chk({t, " tap_idx"}, 32'(tap_idx_out), 32'(c - 3));
      chk({t, " last"}, 32'(last_out), 32'(c == n + 2));
      chk({t, " done"}, 32'(done_out), 32'(c == n + 3));
      chk({t, " ready"}, 32'(ready_out), 32'(c == n + 4));
      chk({t, " busy"}, 32'(busy_out), 32'(c != n + 4));
      chk({t, " overrun"}, 32'(overrun_out), 32'(exp_ovr));
      if (c == n + 4) break;
      if (c == pulse_c) sample_valid_in = 1'b1;
      if (chg && c == 2) ntaps_in = 5'd1;
      tick();
      sample_valid_in = 1'b0;
      if (c == pulse_c) exp_ovr = 1'b1;
    end
    exp_head = (h + 1) % 16;
  endtask

  initial begin
    rst = 1'b1;
    sample_valid_in = 1'b0;
    ntaps_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_reset("in_reset");
    rst = 1'b0;
    tick();
    chk_idle_reset("after_reset");

    // 4 taps at head 0: RD 0,15,14,13; done cycle 7; ready cycle 8
    run_seq("ntaps4", 4, 4, -1, 1'b0);
    // ntaps 0 clamps to a single tap
    run_seq("ntaps0", 0, 1, -1, 1'b0);
    // ntaps 20 clamps to 16, touching every address once
    run_seq("ntaps20", 20, 16, -1, 1'b0);
    // ntaps change mid-READ is ignored
    run_seq("ntaps_chg", 4, 4, -1, 1'b1);
    // stray valid in cycle 3 sets sticky overrun, sequence unaffected
    run_seq("overrun", 4, 4, 3, 1'b0);
    run_seq("post_ovr", 2, 2, -1, 1'b0);
    chk("overrun sticky", 32'(overrun_out), 1);

    // reset mid-sequence (cycle 4) at head 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ovr = 1'b0;
    exp_head = 0;
    sample_valid_in = 1'b1;
    ntaps_in = 5'd4;
    tick();
    sample_valid_in = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk_idle_reset("abort");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("abort no_done %0d", i), 32'(done_out), 0);
      chk($sformatf("abort ready %0d", i), 32'(ready_out), 1);
      tick();
    end
    run_seq("after_abort", 4, 4, -1, 1'b0);

    // 17 back-to-back 2-tap samples: heads 0..15 then wrap to 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_head = 0;
    for (int s = 0; s < 17; s++)
      run_seq($sformatf("b2b%0d", s), 2, 2, -1, 1'b0);
    chk("b2b wrapped head", 32'(exp_head), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
